// File: rtl/fifo_pkg.sv
// fifo_pkg: shared occupancy encoding and default widths for the FIFO read controller.
package fifo_pkg;
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} occ_e;
    localparam int WIDTH_DEF = 8;
    localparam int CNT_W_DEF = 16;
endpackage

// File: rtl/fifo_skid2.sv
// fifo_skid2: 2-entry in-order buffer with push/pop/flush; head is always the oldest entry.
module fifo_skid2
    import fifo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [1:0]       occ,
    output logic [WIDTH-1:0] head
);
    occ_e             occ_q, occ_d;
    logic [WIDTH-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
    logic             do_pop;
    logic [1:0]       keep;
    always_comb begin
        do_pop = pop && occ_q != EMPTY;
        keep   = occ_q - {1'b0, do_pop};
        // entries left after the pop decide which slot a captured word lands in
        ent0_d = do_pop ? ent1_q : ent0_q;
        ent1_d = ent1_q;
        if (push && keep == 2'd0) ent0_d = push_data;
        if (push && keep != 2'd0) ent1_d = push_data;
        occ_d  = flush ? EMPTY : occ_e'(keep + {1'b0, push});
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ_q  <= EMPTY;
            ent0_q <= '0;
            ent1_q <= '0;
        end else begin
            occ_q  <= occ_d;
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
        end
    end
    assign occ  = occ_q;
    assign head = ent0_q;
endmodule

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: turns a 1-cycle-latency FIFO read port into a full-throughput valid/ready stream.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_data,
    input  logic             flush,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [CNT_W-1:0] beat_cnt
);
    logic [1:0]       occ;
    logic             pend_q, pend_d, pop;
    logic [2:0]       level;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    assign m_valid = occ != 2'd0;
    always_comb begin
        pop        = m_valid && m_ready;
        // slots committed after this edge: buffered + in flight - leaving
        level      = {1'b0, occ} + {2'b0, pend_q} - {2'b0, pop};
        fifo_rd_en = !fifo_empty && !flush && rst_n && level < 3'd2;
        pend_d     = fifo_rd_en;
        beat_cnt_d = beat_cnt_q + CNT_W'(pop);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q     <= 1'b0;
            beat_cnt_q <= '0;
        end else begin
            pend_q     <= pend_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end
    assign beat_cnt = beat_cnt_q;
    fifo_skid2 #(.WIDTH(WIDTH)) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (pend_q),
        .push_data(fifo_data),
        .pop      (pop),
        .flush    (flush),
        .occ      (occ),
        .head     (m_data)
    );
endmodule
